// File: rtl/modbus_rtu_master_req_if.sv
// -----------------------------------------------------------------------------
// modbus_rtu_master_req_if
//
// Purpose : Groups the request handshake and the RS485 line signals of the
//           Modbus RTU request source into a single bundle.
//
// Signals :
//   req_start     1   one-cycle request strobe (requester -> source)
//   req_dev_addr  8   slave address byte
//   req_func      8   function code
//   req_addr      16  register address, sent MSB first
//   req_data      16  quantity or write value, sent MSB first
//   req_busy      1   request in progress
//   req_done      1   one-cycle pulse: frame plus 3.5T gap complete
//   req_err       1   one-cycle reject pulse (function check build only)
//   rs485_tx      1   serial line, idle high
//   rs485_oe      1   RS485 driver enable
//
// Modports:
//   master : the requester (drives req_*, observes status and line)
//   slave  : the request source itself (modbus_rtu_master_req)
// -----------------------------------------------------------------------------
interface modbus_rtu_master_req_if;
    logic        req_start;
    logic [7:0]  req_dev_addr;
    logic [7:0]  req_func;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        req_busy;
    logic        req_done;
    logic        req_err;
    logic        rs485_tx;
    logic        rs485_oe;

    modport master (
        output req_start, req_dev_addr, req_func, req_addr, req_data,
        input  req_busy, req_done, req_err, rs485_tx, rs485_oe
    );

    modport slave (
        input  req_start, req_dev_addr, req_func, req_addr, req_data,
        output req_busy, req_done, req_err, rs485_tx, rs485_oe
    );
endinterface

// File: rtl/modbus_rtu_master_req.sv
// -----------------------------------------------------------------------------
// modbus_rtu_master_req
//
// Purpose : Builds an 8-byte Modbus RTU request
//             dev, func, addrH, addrL, dataH, dataL, crcL, crcH
//           computes CRC-16/MODBUS bit-serially over the first six bytes,
//           and serialises the frame 8N1 onto an RS485 line, driving the
//           transmitter enable for half-duplex turnaround. After the frame
//           the line is released and the request stays busy for the 3.5
//           character inter-frame gap before req_done pulses.
//
// Ports   :
//   clk_in    in  1   system clock
//   rst_n_in  in  1   asynchronous, active-low reset
//   bus       slave modport of modbus_rtu_master_req_if (request inputs,
//             busy/done/err status, rs485_tx, rs485_oe)
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  line rate; BIT_CNT = CLK_FREQ/BAUD_RATE must be >= 64
//
// Build option:
//   MODBUS_REQ_FUNC_CHECK_EN  when defined, a request whose function code is
//                             not 03/04/06 is rejected with a one-cycle
//                             req_err pulse and nothing is transmitted.
//                             When undefined, any code is sent and req_err
//                             stays 0.
//
// Timeline of one request (cycle 0 = cycle in which req_start is accepted):
//   cycles 1..48                 CRC, oe=1, tx=1 (driver preamble)
//   cycles 49..49+80*BIT_CNT-1   8 bytes, 10 bits each, back-to-back
//   next BIT_CNT cycles          POST, oe=1, tx=1
//   next 35*BIT_CNT cycles       GAP, oe=0, busy=1
//   following cycle              req_done=1, busy=0, FSM in IDLE
// -----------------------------------------------------------------------------
module modbus_rtu_master_req #(
    parameter int unsigned CLK_FREQ  = 32'd50000000,
    parameter int unsigned BAUD_RATE = 32'd115200
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    modbus_rtu_master_req_if.slave bus
);

    localparam int unsigned BIT_CNT    = CLK_FREQ / BAUD_RATE;
    localparam int unsigned GAP_CNT    = 35 * BIT_CNT;
    // One counter serves the CRC step count, the bit timer and the gap timer;
    // the gap is the longest interval it ever has to cover.
    localparam int unsigned CNT_W      = $clog2(GAP_CNT);
    localparam int unsigned CRC_CYCLES = 48;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_CYCLES - 1);
    localparam logic [15:0]      CRC_INIT = 16'hFFFF;
    localparam logic [15:0]      CRC_POLY = 16'hA001;
    localparam logic [3:0]       STOP_BIT = 4'd9;
    localparam logic [2:0]       LAST_BYTE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CRC     = 3'd1,
        S_TX_BYTE = 3'd2,
        S_POST    = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [3:0]       bit_idx_q,  bit_idx_d;   // 0 start, 1..8 data, 9 stop
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [47:0]      frame_q,    frame_d;     // byte k at [8k +: 8]
    logic [15:0]      crc_q,      crc_d;
    logic             tx_q,       tx_d;
    logic             oe_q,       oe_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;

    logic             func_ok;
    logic [63:0]      tx_word;
    logic [3:0]       next_bit;
    logic [5:0]       data_sel;
    logic             crc_in;
    logic             crc_lsb;
    logic [15:0]      crc_next;

`ifdef MODBUS_REQ_FUNC_CHECK_EN
    assign func_ok = (bus.req_func == 8'h03) || (bus.req_func == 8'h04) ||
                     (bus.req_func == 8'h06);
`else
    assign func_ok = 1'b1;
`endif

    // The whole frame as one vector: data bit i of byte k sits at index 8k+i,
    // so the CRC step count and the {byte, bit} pair address it directly.
    // CRC low byte lands at byte 6, high byte at byte 7.
    assign tx_word = {crc_q, frame_q};

    // Line value for the bit about to start: data bit (next_bit-1) of the
    // current byte. 3-bit wrap maps next_bit 8 to data bit 7.
    assign next_bit = bit_idx_q + 4'd1;
    assign data_sel = {byte_idx_q, next_bit[2:0] - 3'd1};

    // One CRC-16/MODBUS step per clock, LSB of each byte first.
    assign crc_in   = frame_q[cnt_q[5:0]];
    assign crc_lsb  = crc_q[0] ^ crc_in;
    assign crc_next = {1'b0, crc_q[15:1]} ^ (crc_lsb ? CRC_POLY : 16'h0000);

    // NOTE: every variable gets a default at the top of this block so that no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        crc_d      = crc_q;
        tx_d       = tx_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                oe_d   = 1'b0;
                busy_d = 1'b0;
                // done_q marks the cycle right after GAP; a strobe there is
                // treated as arriving before the FSM is ready.
                if (bus.req_start && !done_q) begin
                    if (func_ok) begin
                        frame_d = {bus.req_data[7:0], bus.req_data[15:8],
                                   bus.req_addr[7:0], bus.req_addr[15:8],
                                   bus.req_func,      bus.req_dev_addr};
                        crc_d   = CRC_INIT;
                        cnt_d   = '0;
                        state_d = S_CRC;
                        busy_d  = 1'b1;
                        oe_d    = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end

            S_CRC: begin
                crc_d = crc_next;
                if (cnt_q == CRC_LAST) begin
                    state_d    = S_TX_BYTE;
                    cnt_d      = '0;
                    bit_idx_d  = 4'd0;
                    byte_idx_d = 3'd0;
                    tx_d       = 1'b0;              // start bit of byte 0
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_TX_BYTE: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == STOP_BIT) begin
                        if (byte_idx_q == LAST_BYTE) begin
                            state_d = S_POST;
                            tx_d    = 1'b1;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            byte_idx_d = byte_idx_q + 3'd1;
                            bit_idx_d  = 4'd0;
                            tx_d       = 1'b0;
                        end
                    end else begin
                        bit_idx_d = next_bit;
                        tx_d      = (next_bit == STOP_BIT) ? 1'b1 : tx_word[data_sel];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_POST: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: the frame and CRC registers are reset along with the control
    // state so that a reset mid-frame leaves no stale bytes or partial CRC.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 4'd0;
            byte_idx_q <= 3'd0;
            frame_q    <= '0;
            crc_q      <= CRC_INIT;
            tx_q       <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the previous state, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            frame_q    <= frame_d;
            crc_q      <= crc_d;
            tx_q       <= tx_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_busy = busy_q;
    assign bus.req_done = done_q;
    assign bus.req_err  = err_q;
    assign bus.rs485_tx = tx_q;
    assign bus.rs485_oe = oe_q;

endmodule

// File: tb/tb_modbus_rtu_master_req.sv
// -----------------------------------------------------------------------------
// tb_modbus_rtu_master_req
//
// Self-checking bench for modbus_rtu_master_req. Expected line traffic comes
// from a byte-level CRC-16/MODBUS model and the frame timeline (preamble,
// 10-bit characters, post bit, 3.5T gap) expressed as plain arithmetic on the
// cycle number since accept. Inputs are driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_modbus_rtu_master_req;

    localparam int unsigned CLK_FREQ  = 6_400_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int B          = 64;                 // clocks per bit
    localparam int TX_START   = 49;
    localparam int POST_START = TX_START + 80 * B;
    localparam int GAP_START  = POST_START + B;
    localparam int DONE_CYC   = GAP_START + 35 * B;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         errors;
    logic [7:0] exp_bytes [8];
    logic [7:0] last_dec  [8];

    modbus_rtu_master_req_if bus ();

    modbus_rtu_master_req #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference frame: six payload bytes plus CRC, computed byte-wise.
    task automatic build_expected(input logic [7:0] dev, input logic [7:0] func,
                                  input logic [15:0] addr, input logic [15:0] data);
        logic [15:0] crc;
        exp_bytes[0] = dev;
        exp_bytes[1] = func;
        exp_bytes[2] = addr[15:8];
        exp_bytes[3] = addr[7:0];
        exp_bytes[4] = data[15:8];
        exp_bytes[5] = data[7:0];
        crc = 16'hFFFF;
        for (int k = 0; k < 6; k++) begin
            crc = crc ^ {8'h00, exp_bytes[k]};
            for (int i = 0; i < 8; i++)
                crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        end
        exp_bytes[6] = crc[7:0];
        exp_bytes[7] = crc[15:8];
    endtask

    // Expected line level p cycles after the first start bit begins.
    function automatic logic exp_line(input int p);
        int bitpos;
        int w;
        bitpos = p / B;
        w      = bitpos % 10;
        if (w == 0) return 1'b0;
        if (w == 9) return 1'b1;
        return exp_bytes[bitpos / 10][w - 1];
    endfunction

    task automatic drive_req(input logic [7:0] dev, input logic [7:0] func,
                             input logic [15:0] addr, input logic [15:0] data);
        bus.req_dev_addr = dev;
        bus.req_func     = func;
        bus.req_addr     = addr;
        bus.req_data     = data;
    endtask

    // Issues one request and follows it cycle by cycle to the done pulse.
    // inject_cyc : cycle at which a second strobe is attempted (-1 none)
    // reset_cyc  : cycle at which reset is asserted and the task ends (-1 none)
    // start_at_done : strobe a new request in the req_done cycle
    task automatic run_frame(input string name, input logic [7:0] dev,
                             input logic [7:0] func, input logic [15:0] addr,
                             input logic [15:0] data, input int inject_cyc,
                             input int reset_cyc, input bit start_at_done);
        int pre_bad;
        int post_bad;
        int gap_bad;
        int line_bad [8];
        int p;
        int k;
        int w;
        pre_bad  = 0;
        post_bad = 0;
        gap_bad  = 0;
        for (int j = 0; j < 8; j++) begin
            line_bad[j] = 0;
            last_dec[j] = 8'h00;
        end
        build_expected(dev, func, addr, data);

        @(negedge clk);
        drive_req(dev, func, addr, data);
        bus.req_start = 1'b1;

        for (int c = 1; c <= DONE_CYC; c++) begin
            @(negedge clk);
            bus.req_start = 1'b0;
            // Inputs wander after accept; the latched frame must not follow.
            drive_req(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
            if (c == 1) check({name, "_accept_busy"}, 32'(bus.req_busy), 32'd1);
            if (c == reset_cyc) begin
                rst_n = 1'b0;
                #1;
                check({name, "_rst_tx"},   32'(bus.rs485_tx), 32'd1);
                check({name, "_rst_oe"},   32'(bus.rs485_oe), 32'd0);
                check({name, "_rst_busy"}, 32'(bus.req_busy), 32'd0);
                check({name, "_rst_done"}, 32'(bus.req_done), 32'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (c == inject_cyc) bus.req_start = 1'b1;

            if (c < TX_START) begin
                if (!(bus.rs485_oe === 1'b1 && bus.rs485_tx === 1'b1 &&
                      bus.req_busy === 1'b1 && bus.req_done === 1'b0 &&
                      bus.req_err === 1'b0)) pre_bad++;
            end else if (c < POST_START) begin
                p = c - TX_START;
                k = p / (10 * B);
                if (bus.rs485_tx !== exp_line(p) || bus.rs485_oe !== 1'b1 ||
                    bus.req_busy !== 1'b1 || bus.req_done !== 1'b0) line_bad[k]++;
                if (p % B == B / 2) begin
                    w = (p / B) % 10;
                    if (w >= 1 && w <= 8) last_dec[k][w - 1] = bus.rs485_tx;
                end
            end else if (c < GAP_START) begin
                if (!(bus.rs485_oe === 1'b1 && bus.rs485_tx === 1'b1 &&
                      bus.req_busy === 1'b1 && bus.req_done === 1'b0)) post_bad++;
            end else if (c < DONE_CYC) begin
                if (!(bus.rs485_oe === 1'b0 && bus.rs485_tx === 1'b1 &&
                      bus.req_busy === 1'b1 && bus.req_done === 1'b0)) gap_bad++;
            end else begin
                check({name, "_done_pulse"}, 32'(bus.req_done), 32'd1);
                check({name, "_done_busy"},  32'(bus.req_busy), 32'd0);
                check({name, "_done_oe"},    32'(bus.rs485_oe), 32'd0);
                if (start_at_done) begin
                    drive_req(8'h01, 8'h03, 16'h0000, 16'h0001);
                    bus.req_start = 1'b1;
                end
            end
        end

        check({name, "_preamble"}, 32'(pre_bad), 32'd0);
        for (int j = 0; j < 8; j++) begin
            check({name, "_line_byte", $sformatf("%0d", j)}, 32'(line_bad[j]), 32'd0);
            check({name, "_dec_byte", $sformatf("%0d", j)}, 32'(last_dec[j]),
                  32'(exp_bytes[j]));
        end
        check({name, "_post"}, 32'(post_bad), 32'd0);
        check({name, "_gap"},  32'(gap_bad),  32'd0);

        @(negedge clk);
        bus.req_start = 1'b0;
        check({name, "_done_one_cycle"}, 32'(bus.req_done), 32'd0);
        check({name, "_idle_after"},     32'(bus.req_busy), 32'd0);
    endtask

    initial begin
        int bad;
        int r;
        logic [7:0] rf;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        bus.req_start = 1'b0;
        drive_req(8'h00, 8'h00, 16'h0000, 16'h0000);

        // Reset values while reset is held.
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx",   32'(bus.rs485_tx), 32'd1);
        check("rst_oe",   32'(bus.rs485_oe), 32'd0);
        check("rst_busy", 32'(bus.req_busy), 32'd0);
        check("rst_done", 32'(bus.req_done), 32'd0);
        check("rst_err",  32'(bus.req_err),  32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        // No request: line stays idle.
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (!(bus.rs485_tx === 1'b1 && bus.rs485_oe === 1'b0 &&
                  bus.req_busy === 1'b0 && bus.req_done === 1'b0)) bad++;
        end
        check("idle_line", 32'(bad), 32'd0);

        // Read holding register 0, quantity 1.
        run_frame("f03", 8'h01, 8'h03, 16'h0000, 16'h0001, -1, -1, 1'b0);
        check("f03_crc_lo", 32'(last_dec[6]), 32'h84);
        check("f03_crc_hi", 32'(last_dec[7]), 32'h0A);

        // Write single register; second strobe during byte 3 is dropped,
        // and a strobe in the done cycle is ignored.
        run_frame("f06", 8'h01, 8'h06, 16'h0001, 16'h0003,
                  TX_START + 30 * B + 5, -1, 1'b1);
        check("f06_crc_lo", 32'(last_dec[6]), 32'h98);
        check("f06_crc_hi", 32'(last_dec[7]), 32'h0B);

        // Reset during byte 5, then a fresh request.
        run_frame("rst5", 8'h01, 8'h04, 16'h0010, 16'h0002,
                  TX_START + 50 * B + 3, -1 + TX_START + 50 * B + 4, 1'b0);
        run_frame("after_rst", 8'h11, 8'h03, 16'h006B, 16'h0003, -1, -1, 1'b0);

        // Unsupported function code.
`ifdef MODBUS_REQ_FUNC_CHECK_EN
        @(negedge clk);
        drive_req(8'h01, 8'h10, 16'h0001, 16'h0002);
        bus.req_start = 1'b1;
        @(negedge clk);
        bus.req_start = 1'b0;
        check("f10_err_pulse", 32'(bus.req_err),  32'd1);
        check("f10_busy",      32'(bus.req_busy), 32'd0);
        @(negedge clk);
        check("f10_err_one_cycle", 32'(bus.req_err), 32'd0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!(bus.rs485_tx === 1'b1 && bus.rs485_oe === 1'b0 &&
                  bus.req_busy === 1'b0)) bad++;
        end
        check("f10_line_silent", 32'(bad), 32'd0);
`else
        run_frame("f10", 8'h01, 8'h10, 16'h0001, 16'h0002, -1, -1, 1'b0);
`endif

        // Randomised requests.
        for (int n = 0; n < 2; n++) begin
            r  = int'($urandom_range(2));
            rf = (r == 0) ? 8'h03 : ((r == 1) ? 8'h04 : 8'h06);
            run_frame($sformatf("rnd%0d", n), 8'($urandom), rf,
                      16'($urandom), 16'($urandom), -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
